// File: rtl/systolic_ctrl_pkg.sv
// ============================================================================
// Module   : systolic_ctrl_pkg
// Brief    : Shared configuration and state encoding for the systolic sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_ctrl_pkg;

    localparam int sys_rows           = 5;
    localparam int sys_cols           = 3;
    localparam int w_buffer_depth     = 16;
    localparam int input_buffer_depth = 16;
    localparam int LAT                = sys_rows + sys_cols - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } systolic_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/systolic_ctrl_valid_delay.sv
// ============================================================================
// Module   : systolic_ctrl_valid_delay
// Brief    : Fixed-depth shift register carrying {valid, index} through the array
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_ctrl_valid_delay #(
    parameter int DW    = 5,
    parameter int DEPTH = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_d,
    output logic          o_any
);

    logic [DW-1:0] r_sr [DEPTH];
    logic          w_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_sr[k] <= '0;
            end
        end else begin
            r_sr[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) begin
                r_sr[k] <= r_sr[k-1];
            end
        end
    end

    // Covers the entry and every stage except the output one, so it drops in
    // the same cycle the final valid is presented at o_d.
    always_comb begin
        w_any = i_d[DW-1];
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_any = w_any | r_sr[k][DW-1];
        end
    end

    assign o_d   = r_sr[DEPTH-1];
    assign o_any = w_any;

endmodule

`default_nettype wire

// File: rtl/systolic_ctrl.sv
// ============================================================================
// Module   : systolic_ctrl
// Brief    : Weight-load / input-stream / drain sequencer for the systolic array
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int SYS_ROWS = sys_rows,
    parameter int SYS_COLS = sys_cols,
    parameter int W_DEPTH  = w_buffer_depth,
    parameter int IN_DEPTH = input_buffer_depth,
    parameter int LAT      = SYS_ROWS + SYS_COLS - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          reuse_w,
    input  logic [$clog2(IN_DEPTH+1)-1:0] n_vec,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          w_rd_en,
    output logic [$clog2(W_DEPTH)-1:0]    w_rd_addr,
    output logic                          w_load,
    output logic                          in_rd_en,
    output logic [$clog2(IN_DEPTH)-1:0]   in_rd_addr,
    output logic                          a_valid,
    output logic                          p_valid,
    output logic [$clog2(IN_DEPTH)-1:0]   p_idx
);

    localparam int W_AW  = $clog2(W_DEPTH);
    localparam int IN_AW = $clog2(IN_DEPTH);
    localparam int NV_W  = $clog2(IN_DEPTH + 1);
    localparam int DW    = 1 + IN_AW;

    systolic_ctrl_state_t r_state;

    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_w_rd_en;
    logic [W_AW-1:0]  r_w_addr;
    logic             r_in_rd_en;
    logic [IN_AW-1:0] r_in_addr;
    logic [IN_AW-1:0] r_last_in;
    logic             r_w_load;
    logic             r_w_last;
    logic             r_w_resident;
    logic             r_a_valid;
    logic [IN_AW-1:0] r_a_idx;

    logic             w_nv_ok;
    logic             w_last_w;
    logic             w_last_in;
    logic             w_in_flight;
    logic [DW-1:0]    w_dl_in;
    logic [DW-1:0]    w_dl_out;

    assign w_nv_ok   = (n_vec != '0) && (int'(n_vec) <= IN_DEPTH);
    assign w_last_w  = (r_w_addr == W_AW'(SYS_ROWS - 1));
    assign w_last_in = (r_in_addr == r_last_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_w_rd_en  <= 1'b0;
            r_w_addr   <= '0;
            r_in_rd_en <= 1'b0;
            r_in_addr  <= '0;
            r_last_in  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (!w_nv_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_busy    <= 1'b1;
                            r_last_in <= IN_AW'(n_vec - NV_W'(1));
                            if (reuse_w && r_w_resident) begin
                                r_state    <= ST_STREAM;
                                r_in_rd_en <= 1'b1;
                                r_in_addr  <= '0;
                            end else begin
                                r_state   <= ST_LOAD_W;
                                r_w_rd_en <= 1'b1;
                                r_w_addr  <= '0;
                            end
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (w_last_w) begin
                        r_state    <= ST_STREAM;
                        r_w_rd_en  <= 1'b0;
                        r_in_rd_en <= 1'b1;
                        r_in_addr  <= '0;
                    end else begin
                        r_w_addr <= r_w_addr + W_AW'(1);
                    end
                end
                ST_STREAM: begin
                    if (w_last_in) begin
                        r_state    <= ST_DRAIN;
                        r_in_rd_en <= 1'b0;
                    end else begin
                        r_in_addr <= r_in_addr + IN_AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!w_in_flight) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Buffer data arrives one cycle after the read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_load     <= 1'b0;
            r_w_last     <= 1'b0;
            r_w_resident <= 1'b0;
            r_a_valid    <= 1'b0;
            r_a_idx      <= '0;
        end else begin
            r_w_load  <= r_w_rd_en;
            r_w_last  <= r_w_rd_en && w_last_w;
            r_a_valid <= r_in_rd_en;
            r_a_idx   <= r_in_addr;
            if (r_w_last) begin
                r_w_resident <= 1'b1;
            end
        end
    end

    assign w_dl_in = {r_a_valid, (r_a_valid ? r_a_idx : '0)};

    systolic_ctrl_valid_delay #(
        .DW    (DW),
        .DEPTH (LAT)
    ) u_valid_delay (
        .clk   (clk),
        .rst   (rst),
        .i_d   (w_dl_in),
        .o_d   (w_dl_out),
        .o_any (w_in_flight)
    );

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign w_rd_en    = r_w_rd_en;
    assign w_rd_addr  = r_w_addr;
    assign w_load     = r_w_load;
    assign in_rd_en   = r_in_rd_en;
    assign in_rd_addr = r_in_addr;
    assign a_valid    = r_a_valid;
    assign p_valid    = w_dl_out[DW-1];
    assign p_idx      = w_dl_out[IN_AW-1:0];

endmodule

`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
// ============================================================================
// Module   : tb_systolic_ctrl
// Brief    : Self-checking bench; expected waveforms come from the job timeline
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_ctrl;

    localparam int R    = 5;
    localparam int C    = 3;
    localparam int LATC = R + C - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       reuse_w = 1'b0;
    logic [4:0] n_vec = '0;
    logic       busy, done, err, w_rd_en, w_load, in_rd_en, a_valid, p_valid;
    logic [3:0] w_rd_addr, in_rd_addr, p_idx;

    int n_chk = 0;
    int n_bad = 0;
    bit model_res = 1'b0;

    systolic_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reuse_w    (reuse_w),
        .n_vec      (n_vec),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .w_rd_en    (w_rd_en),
        .w_rd_addr  (w_rd_addr),
        .w_load     (w_load),
        .in_rd_en   (in_rd_en),
        .in_rd_addr (in_rd_addr),
        .a_valid    (a_valid),
        .p_valid    (p_valid),
        .p_idx      (p_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string where);
        chk({where, ":busy"},     busy,       0);
        chk({where, ":done"},     done,       0);
        chk({where, ":err"},      err,        0);
        chk({where, ":w_rd_en"},  w_rd_en,    0);
        chk({where, ":w_addr"},   w_rd_addr,  0);
        chk({where, ":w_load"},   w_load,     0);
        chk({where, ":in_rd_en"}, in_rd_en,   0);
        chk({where, ":in_addr"},  in_rd_addr, 0);
        chk({where, ":a_valid"},  a_valid,    0);
        chk({where, ":p_valid"},  p_valid,    0);
        chk({where, ":p_idx"},    p_idx,      0);
    endtask

    // Expected outputs at cycle c of a job started at cycle 0.
    task automatic check_cycle(input int c, input bit full, input int nv);
        int  L;
        int  last;
        bit  wen, ien, pv;
        L    = full ? R : 0;
        last = L + nv + 2 + LATC;
        wen  = full && c >= 1 && c <= R;
        ien  = c >= L + 1 && c <= L + nv;
        pv   = c >= L + 2 + LATC && c <= L + nv + 1 + LATC;
        chk($sformatf("busy@%0d", c),     busy,     (c >= 1 && c <= last));
        chk($sformatf("done@%0d", c),     done,     (c == last));
        chk($sformatf("err@%0d", c),      err,      0);
        chk($sformatf("w_rd_en@%0d", c),  w_rd_en,  wen);
        if (wen) chk($sformatf("w_addr@%0d", c), w_rd_addr, c - 1);
        chk($sformatf("w_load@%0d", c),   w_load,   (full && c >= 2 && c <= R + 1));
        chk($sformatf("in_rd_en@%0d", c), in_rd_en, ien);
        if (ien) chk($sformatf("in_addr@%0d", c), in_rd_addr, c - L - 1);
        chk($sformatf("a_valid@%0d", c),  a_valid,  (c >= L + 2 && c <= L + nv + 1));
        chk($sformatf("p_valid@%0d", c),  p_valid,  pv);
        if (pv) chk($sformatf("p_idx@%0d", c), p_idx, c - (L + 2 + LATC));
    endtask

    task automatic run_job(input int nv, input bit reuse);
        bit full;
        int last;
        full = !(reuse && model_res);
        last = (full ? R : 0) + nv + 2 + LATC;
        @(posedge clk);
        #1;
        start   = 1'b1;
        n_vec   = 5'(nv);
        reuse_w = reuse;
        for (int c = 0; c <= last + 2; c++) begin
            @(negedge clk);
            check_cycle(c, full, nv);
            if (c >= 1) begin
                start   = (c < last) ? 1'($urandom_range(0, 1)) : 1'b0;
                n_vec   = 5'($urandom);
                reuse_w = 1'($urandom);
            end
        end
        if (full) model_res = 1'b1;
    endtask

    task automatic run_err(input int nv);
        @(posedge clk);
        #1;
        start   = 1'b1;
        n_vec   = 5'(nv);
        reuse_w = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("rej%0d:err@%0d", nv, c),      err,      (c == 1));
            chk($sformatf("rej%0d:busy@%0d", nv, c),     busy,     0);
            chk($sformatf("rej%0d:w_rd_en@%0d", nv, c),  w_rd_en,  0);
            chk($sformatf("rej%0d:in_rd_en@%0d", nv, c), in_rd_en, 0);
            if (c >= 1) start = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        run_job(3, 1'b1);
        run_job(3, 1'b0);
        run_job(3, 1'b1);
        run_err(0);
        run_err(17);
        run_job(16, 1'b0);
        run_job(16, 1'b1);
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(1, 16), 1'($urandom));
        end

        // Abort a full job at cycle 10.
        @(posedge clk);
        #1;
        start   = 1'b1;
        n_vec   = 5'd5;
        reuse_w = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            check_cycle(c, 1'b1, 5);
            if (c >= 1) start = 1'b0;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort:done@%0d", c), done, 0);
            chk($sformatf("abort:busy@%0d", c), busy, 0);
        end
        rst = 1'b0;
        model_res = 1'b0;
        run_job(3, 1'b1);
        run_job($urandom_range(1, 16), 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the weight-stationary systolic array. On a start request it streams one weight tile from the weight buffer into the array, then streams a batch of input vectors from the input buffer. It tracks the array's fill/drain latency and flags each result row as it leaves the array. It sits between the host/command logic and the array plus its two buffers, and drives all of their read and valid strobes.

## Interface
- SYS_ROWS, 5, array rows (weight rows loaded per tile)
- SYS_COLS, 3, array columns
- W_DEPTH, 16, weight buffer depth
- IN_DEPTH, 16, input buffer depth
- LAT, SYS_ROWS+SYS_COLS-1, cycles from array input valid to matching result valid
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a job; sampled only in IDLE
- reuse_w  in  1  with start: skip weight load if a tile is already resident
- n_vec  in  $clog2(IN_DEPTH+1)  input vectors in job, legal 1..IN_DEPTH
- busy  out  1  job in progress
- done  out  1  one-cycle pulse, job complete
- err  out  1  one-cycle pulse, start rejected
- w_rd_en  out  1  weight buffer read strobe
- w_rd_addr  out  $clog2(W_DEPTH)  weight row address
- w_load  out  1  array shifts in weight row (buffer data valid)
- in_rd_en  out  1  input buffer read strobe
- in_rd_addr  out  $clog2(IN_DEPTH)  input vector address
- a_valid  out  1  array input vector valid
- p_valid  out  1  result row valid at array output
- p_idx  out  $clog2(IN_DEPTH)  vector index of current result row

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE, start=1:
  - n_vec==0 or n_vec>IN_DEPTH: err pulses next cycle; stay IDLE.
  - else if reuse_w && w_resident: go to STREAM.
  - else: go to LOAD_W.
- LOAD_W: w_rd_en=1, w_rd_addr counts 0..SYS_ROWS-1. Last address -> STREAM.
- STREAM: in_rd_en=1, in_rd_addr counts 0..n_vec-1. Last address -> DRAIN.
- DRAIN: wait until the delay line is empty, i.e. the last p_valid has been emitted -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Buffer read latency is 1 cycle:
  - w_load = w_rd_en delayed 1.
  - a_valid = in_rd_en delayed 1.
- p_valid/p_idx = (a_valid, vector index) delayed LAT cycles.
- w_resident flag: set on the last w_load. Cleared only by rst.
- n_vec is latched on accept. Later changes are ignored.
- start while busy: ignored, no err.
- busy=1 in every non-IDLE state, including DONE.

## Timing
- Reset values: every output 0, state IDLE, counters 0, delay line cleared, w_resident 0.
- rst mid-job aborts immediately; no done pulse is issued.
- Full job, start at cycle 0:
  - w_rd_en cycles 1..SYS_ROWS; w_load cycles 2..SYS_ROWS+1.
  - in_rd_en cycles SYS_ROWS+1..SYS_ROWS+n_vec; a_valid one cycle later.
  - p_valid from SYS_ROWS+2+LAT, for n_vec cycles.
  - done one cycle after the last p_valid.
- Reuse job, start at cycle 0: in_rd_en cycles 1..n_vec; a_valid 2..n_vec+1; p_valid 2+LAT..n_vec+1+LAT; done n_vec+2+LAT.
- The last w_load and the first a_valid never share a cycle.
- Counters stop at their terminal values. There is no wrap-around within a job.
- n_vec==IN_DEPTH: in_rd_addr reaches IN_DEPTH-1, then stops.

## Structure
- The Config package gains the state typedef systolic_ctrl_state_t and LAT. The SYS_ROWS/SYS_COLS/depth defaults come from sys_rows, sys_cols, w_buffer_depth and input_buffer_depth in that package.
- One sub-module, valid_delay: a parameterised shift register of width 1+$clog2(IN_DEPTH), depth LAT, with async reset. It also outputs an "any valid in flight" signal, which DRAIN uses.

## Test plan
- Reset, then start, n_vec=3, reuse_w=0, at cycle 0 -> w_rd_en 1..5 (addr 0..4), w_load 2..6, in_rd_en 6..8 (addr 0..2), a_valid 7..9, p_valid 14..16 with p_idx 0,1,2, done 17, busy 1..17.
- Same job repeated with reuse_w=1 -> no w_rd_en, in_rd_en 1..3, p_valid 9..11, done 12.
- reuse_w=1 directly after reset -> full weight load occurs (w_resident=0).
- start with n_vec=0, then n_vec=17 -> err pulse each time, busy stays 0, no buffer reads.
- n_vec=16 -> in_rd_addr 0..15, p_idx 0..15, exactly 16 p_valid; start pulses during busy produce no effect.
- rst asserted at cycle 10 of a full job -> all outputs 0 at once, no done; a subsequent reuse_w=1 start performs a full weight load.
